emu_reset_sequencer: RTL and testbench

Consumes the raw emulated reset request produced by the platform's reset component, synchronizes and deglitches it into the `clk` domain, and drives a set of staged, active-high reset outputs to the target design. All stages assert together. After a minimum hold time they release one at a time, in index order, with a fixed gap between releases. It also reports sequencing status and keeps a saturating count of filtered reset requests.

---
 rtl/emu_reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_emu_reset_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_reset_sequencer.sv
// Staged reset sequencer: synchronizes and deglitches an emulated reset request,
// then releases active-high reset stages one at a time after a hold period.
//
// state      | meaning
// -----------|-----------------------------------------------------------
// ST_ASSERT  | all stages asserted, waiting for filtered request to drop
// ST_HOLD    | all stages asserted, hold timer running
// ST_RELEASE | stages releasing low-to-high, one per gap interval
// ST_IDLE    | all stages released
module emu_reset_sequencer #(
   parameter int STAGES        = 4,
   parameter int HOLD_CYCLES   = 16,
   parameter int GAP_CYCLES    = 4,
   parameter int FILTER_CYCLES = 2,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   reset_req,
   output logic [STAGES-1:0]      stage_reset,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] req_count
);

   localparam int FW   = $clog2(FILTER_CYCLES + 1);
   localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
   localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_IDLE    = 2'd3
   } state_t;

   logic                   sync1_q, sync1_d;
   logic                   req_s_q, req_s_d;
   logic                   req_f_q, req_f_d;
   logic [FW-1:0]          flt_cnt_q, flt_cnt_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   state_t                 state_q, state_d;
   logic [TW-1:0]          tmr_q, tmr_d;
   logic [STAGES-1:0]      stage_q, stage_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   // Synchronizer, glitch filter and saturating request counter.
   always_comb begin
      sync1_d   = reset_req;
      req_s_d   = sync1_q;
      req_f_d   = req_f_q;
      flt_cnt_d = '0;
      if (req_s_q != req_f_q) begin
         if (flt_cnt_q == FILT_LAST) begin
            req_f_d = req_s_q;
         end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
         end
      end
      cnt_d = cnt_q;
      if (req_f_d && !req_f_q && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Down-counting timer; releases happen by shifting zeros in from bit 0,
   // so the sequence is finished once the shifted vector is empty.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      stage_d = stage_q;
      done_d  = 1'b0;
      case (state_q)
         ST_ASSERT: begin
            stage_d = '1;
            if (!req_f_q) begin
               state_d = ST_HOLD;
               tmr_d   = HOLD_LOAD;
            end
         end
         ST_HOLD, ST_RELEASE: begin
            if (req_f_q) begin
               state_d = ST_ASSERT;
               stage_d = '1;
            end else if (tmr_q == '0) begin
               stage_d = stage_q << 1;
               tmr_d   = GAP_LOAD;
               if (stage_d == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RELEASE;
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         ST_IDLE: begin
            stage_d = '0;
            if (req_f_q) begin
               state_d = ST_ASSERT;
               stage_d = '1;
            end
         end
         default: begin
            state_d = ST_ASSERT;
            stage_d = '1;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q   <= 1'b1;
         req_s_q   <= 1'b1;
         req_f_q   <= 1'b1;
         flt_cnt_q <= '0;
         cnt_q     <= '0;
         state_q   <= ST_ASSERT;
         tmr_q     <= '0;
         stage_q   <= '1;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         req_s_q   <= req_s_d;
         req_f_q   <= req_f_d;
         flt_cnt_q <= flt_cnt_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         stage_q   <= stage_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign stage_reset = stage_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign req_count   = cnt_q;

endmodule

// File: tb/tb_emu_reset_sequencer.sv
// Scoreboard bench for emu_reset_sequencer: an elapsed-time reference model queues
// the expected outputs each edge and a negedge monitor compares them.
module tb_emu_reset_sequencer;

   localparam int STAGES = 4;
   localparam int HOLD   = 16;
   localparam int GAP    = 4;
   localparam int FILT   = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        reset_req = 1'b0;
   logic [3:0]  stage_reset, stage_reset4;
   logic        busy, done, busy4, done4;
   logic [15:0] req_count;
   logic [3:0]  req_count4;

   always #5 clk = ~clk;

   emu_reset_sequencer #(.STAGES(4), .HOLD_CYCLES(16), .GAP_CYCLES(4),
                         .FILTER_CYCLES(2), .COUNT_WIDTH(16)) dut (
      .clk(clk), .resetn(resetn), .reset_req(reset_req),
      .stage_reset(stage_reset), .busy(busy), .done(done), .req_count(req_count));

   emu_reset_sequencer #(.STAGES(4), .HOLD_CYCLES(16), .GAP_CYCLES(4),
                         .FILTER_CYCLES(2), .COUNT_WIDTH(4)) dut4 (
      .clk(clk), .resetn(resetn), .reset_req(reset_req),
      .stage_reset(stage_reset4), .busy(busy4), .done(done4), .req_count(req_count4));

   typedef struct packed {
      logic [3:0]  stage;
      logic        busy;
      logic        done;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: request pipeline plus time elapsed since the hold began.
   bit     m_sync1, m_req_s, m_req_f, m_seq;
   int     m_diff, m_cnt, m_cnt4;
   longint m_n, m_h;
   bit     n_sync1, n_req_s, n_req_f;
   int     n_diff;

   function automatic exp_t model_out();
      exp_t   r;
      longint t;
      int     rel;
      r.cnt  = 16'(m_cnt);
      r.cnt4 = 4'(m_cnt4);
      if (!m_seq) begin
         r.stage = 4'hF;
         r.busy  = 1'b1;
         r.done  = 1'b0;
      end else begin
         t = m_n - m_h;
         if (t < HOLD) rel = 0;
         else rel = 1 + int'((t - HOLD) / GAP);
         if (rel > STAGES) rel = STAGES;
         r.stage = 4'(((1 << STAGES) - 1) & ~((1 << rel) - 1));
         r.busy  = (rel < STAGES);
         r.done  = (t == HOLD + (STAGES - 1) * GAP);
      end
      return r;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_sync1 = 1; m_req_s = 1; m_req_f = 1; m_seq = 0;
         m_diff = 0; m_cnt = 0; m_cnt4 = 0; m_n = 0; m_h = 0;
         exp_q.delete();
         exp_q.push_back(model_out());
      end else begin
         n_sync1 = reset_req;
         n_req_s = m_sync1;
         n_req_f = m_req_f;
         n_diff  = 0;
         if (m_req_s != m_req_f) begin
            n_diff = m_diff + 1;
            if (n_diff == FILT) begin
               n_req_f = m_req_s;
               n_diff  = 0;
            end
         end
         if (n_req_f && !m_req_f) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
         end
         m_n = m_n + 1;
         if (!m_seq && !m_req_f) begin
            m_seq = 1;
            m_h   = m_n;
         end else if (m_seq && m_req_f) begin
            m_seq = 0;
         end
         m_sync1 = n_sync1;
         m_req_s = n_req_s;
         m_req_f = n_req_f;
         m_diff  = n_diff;
         exp_q.push_back(model_out());
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (stage_reset !== e.stage || busy !== e.busy || done !== e.done ||
             req_count !== e.cnt || req_count4 !== e.cnt4 ||
             stage_reset4 !== e.stage || busy4 !== e.busy || done4 !== e.done) begin
            errors++;
            $display("FAIL cycle_check t=%0t got stage=%h busy=%b done=%b cnt=%0d cnt4=%0d stage4=%h busy4=%b done4=%b want stage=%h busy=%b done=%b cnt=%0d cnt4=%0d",
                     $time, stage_reset, busy, done, req_count, req_count4,
                     stage_reset4, busy4, done4, e.stage, e.busy, e.done, e.cnt, e.cnt4);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int len);
      @(negedge clk);
      reset_req = 1'b1;
      repeat (len) @(negedge clk);
      reset_req = 1'b0;
   endtask

   task automatic wait_stage(input logic [3:0] target);
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (stage_reset == target) found = 1;
      end
      chk("wait_stage", 32'(found), 32'd1);
   endtask

   // resetn has just been released at a negedge; the next posedge is edge 0.
   task automatic pwrup_check();
      logic [3:0] want;
      for (int e = 0; e <= 36; e++) begin
         @(posedge clk);
         #1;
         if (e < 20) want = 4'hF;
         else if (e < 24) want = 4'hE;
         else if (e < 28) want = 4'hC;
         else if (e < 32) want = 4'h8;
         else want = 4'h0;
         chk("pwrup_stage", 32'(stage_reset), 32'(want));
         chk("pwrup_busy", 32'(busy), 32'(e < 32));
         chk("pwrup_done", 32'(done), 32'(e == 32));
      end
      chk("pwrup_count", 32'(req_count), 32'd0);
   endtask

   initial begin
      resetn = 1'b0;
      reset_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_stage", 32'(stage_reset), 32'hF);
      chk("reset_busy", 32'(busy), 32'd1);
      resetn = 1'b1;
      pwrup_check();

      // Single-cycle glitch rejected, two-cycle pulse accepted.
      pulse(1);
      cycles(20);
      chk("glitch1_stage", 32'(stage_reset), 32'h0);
      chk("glitch1_busy", 32'(busy), 32'd0);
      chk("glitch1_count", 32'(req_count), 32'd0);
      pulse(2);
      cycles(50);
      chk("glitch2_count", 32'(req_count), 32'd1);
      chk("glitch2_stage", 32'(stage_reset), 32'h0);

      // Ten-cycle request from IDLE: full reassert at edge 4.
      @(negedge clk);
      reset_req = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk("req_edge3_stage", 32'(stage_reset), 32'h0);
      @(posedge clk);
      #1 chk("req_edge4_stage", 32'(stage_reset), 32'hF);
      chk("req_edge4_count", 32'(req_count), 32'd2);
      repeat (6) @(negedge clk);
      reset_req = 1'b0;
      cycles(50);

      // Re-request while half released.
      pulse(3);
      wait_stage(4'hC);
      reset_req = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("rereq_stage", 32'(stage_reset), 32'hF);
      chk("rereq_count", 32'(req_count), 32'd4);
      cycles(6);
      reset_req = 1'b0;
      cycles(50);

      // Asynchronous reset in the middle of a release.
      pulse(3);
      wait_stage(4'hC);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("arst_stage", 32'(stage_reset), 32'hF);
      chk("arst_busy", 32'(busy), 32'd1);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_count", 32'(req_count), 32'd0);
      cycles(2);
      resetn = 1'b1;
      pwrup_check();

      // Saturation of the narrow counter.
      for (int k = 0; k < 17; k++) begin
         pulse(3);
         cycles(8);
      end
      cycles(40);
      chk("sat_count4", 32'(req_count4), 32'd15);
      chk("sat_count16", 32'(req_count), 32'd17);
      chk("sat_stage4", 32'(stage_reset4), 32'h0);

      // Randomized pulses: glitches, short and long requests, varied gaps.
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 2) == 0) pulse($urandom_range(5, 30));
         else pulse($urandom_range(1, 4));
         cycles($urandom_range(1, 60));
      end
      cycles(60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
